// File: rtl/svnet_ram_arbiter.sv
// Round-robin arbiter that shares one svnet_ram between NUM_CLIENTS requesters,
// tagging in-flight reads so returned data is routed back to the right client.
module svnet_ram_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int WIDTH       = 1,
    parameter int DEPTH       = 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CLIENTS-1:0]              client_req,
    input  logic [NUM_CLIENTS-1:0]              client_write,
    input  logic [NUM_CLIENTS-1:0][AW-1:0]      client_address,
    input  logic [NUM_CLIENTS-1:0][WIDTH-1:0]   client_write_data,
    output logic [NUM_CLIENTS-1:0]              client_grant,
    output logic [NUM_CLIENTS-1:0]              client_read_data_valid,
    output logic [WIDTH-1:0]                    client_read_data,
    output logic                                ram_write,
    output logic [AW-1:0]                       ram_write_address,
    output logic [WIDTH-1:0]                    ram_write_data,
    output logic                                ram_read,
    output logic [AW-1:0]                       ram_read_address,
    input  logic                                ram_read_data_valid,
    input  logic [WIDTH-1:0]                    ram_read_data,
    output logic                                address_error
);

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gidx;
    logic             any;
    logic             addr_bad;
    int unsigned      scan;
    logic [IW-1:0]    issue_idx;
    logic             tag1_v, tag2_v;
    logic [IW-1:0]    tag1_i, tag2_i;

    // Grant is forced low during reset so no request is seen as accepted.
    always_comb begin
        client_grant = '0;
        gidx         = '0;
        any          = 1'b0;
        scan         = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            scan = (32'(ptr) + 32'(i)) % 32'(NUM_CLIENTS);
            if (!any && rst_n && client_req[IW'(scan)]) begin
                any  = 1'b1;
                gidx = IW'(scan);
            end
        end
        if (any) client_grant[gidx] = 1'b1;
    end

    assign addr_bad = any && (32'(client_address[gidx]) >= 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr               <= '0;
            ram_write         <= 1'b0;
            ram_read          <= 1'b0;
            ram_write_address <= '0;
            ram_write_data    <= '0;
            ram_read_address  <= '0;
            issue_idx         <= '0;
            tag1_v            <= 1'b0;
            tag1_i            <= '0;
            tag2_v            <= 1'b0;
            tag2_i            <= '0;
            address_error     <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            ram_read  <= 1'b0;
            if (any) begin
                ptr <= (gidx == IW'(NUM_CLIENTS - 1)) ? '0 : gidx + 1'b1;
                if (addr_bad) begin
                    address_error <= 1'b1;
                end else if (client_write[gidx]) begin
                    ram_write         <= 1'b1;
                    ram_write_address <= client_address[gidx];
                    ram_write_data    <= client_write_data[gidx];
                end else begin
                    ram_read          <= 1'b1;
                    ram_read_address  <= client_address[gidx];
                    issue_idx         <= gidx;
                end
            end
            // Tags trail ram_read by the RAM's two-cycle read-to-valid delay.
            tag1_v <= ram_read;
            tag1_i <= issue_idx;
            tag2_v <= tag1_v;
            tag2_i <= tag1_i;
        end
    end

    always_comb begin
        client_read_data_valid = '0;
        if (ram_read_data_valid && tag2_v) client_read_data_valid[tag2_i] = 1'b1;
    end

    assign client_read_data = ram_read_data;

    cover property (@(posedge clk) disable iff (!rst_n) addr_bad);

    tag_integrity: assert property (@(posedge clk) disable iff (!rst_n)
        ram_read_data_valid == tag2_v);

endmodule

// File: tb/tb_svnet_ram_arbiter.sv
// Directed plus randomized bench for svnet_ram_arbiter with a behavioural RAM
// and a grant-order reference model.
module tb_svnet_ram_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 12;
    localparam int AW = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N-1:0]        client_req;
    logic [N-1:0]        client_write;
    logic [N-1:0][AW-1:0] client_address;
    logic [N-1:0][W-1:0] client_write_data;
    logic [N-1:0]        client_grant;
    logic [N-1:0]        client_read_data_valid;
    logic [W-1:0]        client_read_data;
    logic                ram_write;
    logic [AW-1:0]       ram_write_address;
    logic [W-1:0]        ram_write_data;
    logic                ram_read;
    logic [AW-1:0]       ram_read_address;
    logic                ram_read_data_valid;
    logic [W-1:0]        ram_read_data;
    logic                address_error;

    svnet_ram_arbiter #(.NUM_CLIENTS(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .client_req(client_req), .client_write(client_write),
        .client_address(client_address), .client_write_data(client_write_data),
        .client_grant(client_grant), .client_read_data_valid(client_read_data_valid),
        .client_read_data(client_read_data),
        .ram_write(ram_write), .ram_write_address(ram_write_address),
        .ram_write_data(ram_write_data), .ram_read(ram_read),
        .ram_read_address(ram_read_address),
        .ram_read_data_valid(ram_read_data_valid), .ram_read_data(ram_read_data),
        .address_error(address_error)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write commits at the edge, read data valid two cycles after ram_read.
    logic [W-1:0] ram_mem [16];
    logic         v1 = 1'b0, v2 = 1'b0;
    logic [W-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_write_address] <= ram_write_data;
        v1 <= ram_read;
        d1 <= ram_mem[ram_read_address];
        v2 <= v1;
        d2 <= d1;
    end
    assign ram_read_data_valid = v2;
    assign ram_read_data       = d2;

    typedef struct {
        int          due;
        int          cli;
        logic [W-1:0] data;
    } ret_t;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           m_ptr;
    logic [W-1:0] m_mem [16];
    logic         m_err;
    ret_t         pend [$];
    logic         e_wr, e_rd;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [W-1:0] e_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_err   = 1'b0;
        pend.delete();
        e_wr    = 1'b0;
        e_rd    = 1'b0;
        e_waddr = '0;
        e_raddr = '0;
        e_wdata = '0;
    endtask

    // One cycle: check outputs against the model, then advance the model past the edge.
    task automatic tick();
        int           g;
        int           a;
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        logic [W-1:0] ed;
        #1;
        if (!rst_n) model_reset();
        g = -1;
        if (rst_n)
            for (int i = 0; i < N; i++)
                if (g < 0 && client_req[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        chk("grant", 32'(client_grant), 32'(eg));
        chk("ram_write", 32'(ram_write), 32'(e_wr));
        chk("ram_read", 32'(ram_read), 32'(e_rd));
        chk("ram_write_address", 32'(ram_write_address), 32'(e_waddr));
        chk("ram_write_data", 32'(ram_write_data), 32'(e_wdata));
        chk("ram_read_address", 32'(ram_read_address), 32'(e_raddr));
        chk("address_error", 32'(address_error), 32'(m_err));
        ev = '0;
        ed = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ev[pend[0].cli] = 1'b1;
            ed = pend[0].data;
            void'(pend.pop_front());
        end
        chk("read_valid", 32'(client_read_data_valid), 32'(ev));
        if (ev != '0) chk("read_data", 32'(client_read_data), 32'(ed));
        e_wr = 1'b0;
        e_rd = 1'b0;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            a = int'(client_address[g]);
            if (a >= D) begin
                m_err = 1'b1;
            end else if (client_write[g]) begin
                m_mem[a] = client_write_data[g];
                e_wr = 1'b1;
                e_waddr = AW'(a);
                e_wdata = client_write_data[g];
            end else begin
                e_rd = 1'b1;
                e_raddr = AW'(a);
                pend.push_back('{due: cyc + 3, cli: g, data: m_mem[a]});
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic one(input int c, input logic w, input int a, input int d);
        client_req = '0;
        client_req[c] = 1'b1;
        client_write[c] = w;
        client_address[c] = AW'(a);
        client_write_data[c] = W'(d);
    endtask

    task automatic idle(input int n);
        client_req = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        model_reset();
        rst_n = 1'b0;
        client_req = '0;
        client_write = '0;
        client_address = '0;
        client_write_data = '0;
        tick();
        tick();
        rst_n = 1'b1;
        idle(1);

        // Client 2 writes then reads address 5.
        one(2, 1'b1, 5, 8'hA5); tick();
        one(2, 1'b0, 5, 0);     tick();
        idle(5);

        // Pointer skip: move ptr to 2, then 1010 grants 3, then 1.
        one(1, 1'b0, 0, 0); tick();
        client_req = 4'b1010; client_write = '0; tick();
        client_req = 4'b1010; tick();
        idle(4);

        // Read-write-read on the same address.
        one(0, 1'b1, 1, 8'h11); tick();
        idle(1);
        one(0, 1'b0, 1, 0);     tick();
        one(1, 1'b1, 1, 8'h22); tick();
        one(0, 1'b0, 1, 0);     tick();
        idle(5);

        // Out-of-range address: consumed, flagged, nothing issued.
        one(1, 1'b0, 13, 0); tick();
        idle(5);

        // Reset while a read is in flight.
        one(3, 1'b0, 5, 0); tick();
        idle(1);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // Fairness: all four clients read continuously from ptr = 0.
        client_req = 4'b1111;
        client_write = '0;
        for (int i = 0; i < N; i++) client_address[i] = AW'(i + 4);
        for (int i = 0; i < 12; i++) tick();
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            client_req   = N'($urandom);
            client_write = N'($urandom);
            for (int c = 0; c < N; c++) begin
                client_address[c]    = AW'($urandom_range(0, 15));
                client_write_data[c] = W'($urandom);
            end
            tick();
        end
        idle(6);
        chk("drain", 32'(pend.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
